lsu_ctrl: RTL and testbench

- Load/store control stage directly upstream of the byte-addressed data memory. The data memory is 1-cycle registered read and returns 0 when not reading.
- Accepts one memory request at a time from the execute stage over a valid/ready handshake.
- Checks alignment, range and funct3 legality, drives the memory strobes for exactly one cycle, and captures the load result.
- Presents the result to writeback over a valid/ready handshake.

---
 rtl/lsu_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl -- load/store control stage in front of the byte-addressed data memory.
//
// Takes one request at a time from execute, screens it for op legality, range
// and alignment, strobes the memory for exactly one cycle, captures the load
// data returned one cycle later, and hands the result to writeback.
//
// Ports:
//   Clock, nReset                 rising-edge clock, synchronous active-low reset
//   req_*  (valid/ready)          request from execute: load/store, funct3, address,
//                                 store data, destination tag
//   mem_*                         memory strobes, funct3, address, store data;
//                                 mem_rdata is valid the cycle after mem_Rmem
//   resp_* (valid/ready)          response to writeback: load data, tag, fault flags
//   cnt_loads/stores/faults       performance counters
//
// Build option:
//   LSU_PERF_CNT_EN  when defined, the cnt_* ports count completed responses by
//                    kind; when undefined they are tied to 0 and no counters exist.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | req_ready high, waiting for a request
// ISSUE | memory strobe asserted for this single cycle
// WAIT  | load data arriving from memory, captured at the end of the cycle
// RESP  | resp_valid high, holding until writeback accepts

module lsu_ctrl #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic              req_store,
  input  logic [2:0]        req_f3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_Rmem,
  output logic              mem_Wmem,
  output logic [2:0]        mem_f3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [4:0]        resp_rd,
  output logic              resp_misaligned,
  output logic              resp_fault,
  output logic [31:0]       cnt_loads,
  output logic [31:0]       cnt_stores,
  output logic [31:0]       cnt_faults
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;

  logic              accept;
  logic [ADDR_W:0]   acc_size;
  logic [ADDR_W:0]   acc_end;
  logic              acc_op_bad;
  logic              acc_range_bad;
  logic              acc_misaligned;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Access size from funct3[1:0]; the reserved encoding 11 is treated as a word.
  always_comb begin
    case (req_f3[1:0])
      2'b00:   acc_size = (ADDR_W+1)'(1);
      2'b01:   acc_size = (ADDR_W+1)'(2);
      default: acc_size = (ADDR_W+1)'(4);
    endcase
  end

  // One extra bit so an address near the top of the space cannot wrap past the check.
  assign acc_end       = {1'b0, req_addr} + acc_size;
  assign acc_range_bad = acc_end > (ADDR_W+1)'(MEM_BYTES);

  assign acc_op_bad = (req_load == req_store)
                   || (req_load  && (req_f3 == 3'b011 || req_f3[2:1] == 2'b11))
                   || (req_store && (req_f3 > 3'b010));

  assign acc_misaligned = ((req_f3[1:0] == 2'b01) && req_addr[0])
                       || (req_f3[1] && (req_addr[1:0] != 2'b00));

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state           <= IDLE;
      mem_Rmem        <= 1'b0;
      mem_Wmem        <= 1'b0;
      mem_f3          <= '0;
      mem_addr        <= '0;
      mem_data        <= '0;
      resp_valid      <= 1'b0;
      resp_data       <= '0;
      resp_rd         <= '0;
      resp_misaligned <= 1'b0;
      resp_fault      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            resp_rd <= req_rd;
            if (acc_op_bad || acc_range_bad || acc_misaligned) begin
              // Faults skip the memory entirely and answer on the next cycle.
              resp_valid      <= 1'b1;
              resp_data       <= '0;
              resp_fault      <= acc_op_bad || acc_range_bad;
              resp_misaligned <= acc_misaligned;
              state           <= RESP;
            end else begin
              mem_Rmem        <= req_load;
              mem_Wmem        <= req_store;
              mem_f3          <= req_f3;
              mem_addr        <= req_addr;
              mem_data        <= req_wdata;
              resp_fault      <= 1'b0;
              resp_misaligned <= 1'b0;
              state           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_Rmem <= 1'b0;
          mem_Wmem <= 1'b0;
          mem_f3   <= '0;
          mem_addr <= '0;
          mem_data <= '0;
          if (mem_Rmem) begin
            state <= WAIT;
          end else begin
            resp_valid <= 1'b1;
            resp_data  <= '0;
            state      <= RESP;
          end
        end
        WAIT: begin
          resp_data  <= mem_rdata;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid      <= 1'b0;
            resp_data       <= '0;
            resp_fault      <= 1'b0;
            resp_misaligned <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic kind_load;

  // The kind is remembered at acceptance; the fault flags are still valid in RESP.
  always_ff @(posedge Clock) begin
    if (!nReset) begin
      kind_load  <= 1'b0;
      cnt_loads  <= '0;
      cnt_stores <= '0;
      cnt_faults <= '0;
    end else begin
      if (accept) kind_load <= req_load;
      if (state == RESP && resp_ready) begin
        if (resp_fault || resp_misaligned) cnt_faults <= cnt_faults + 32'd1;
        else if (kind_load)                cnt_loads  <= cnt_loads  + 32'd1;
        else                               cnt_stores <= cnt_stores + 32'd1;
      end
    end
  end
`else
  assign cnt_loads  = '0;
  assign cnt_stores = '0;
  assign cnt_faults = '0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
`timescale 1ns/1ps
// Testbench for lsu_ctrl: directed scenarios followed by randomized requests,
// compared against a transaction-level reference model (byte array + counters).

module tb_lsu_ctrl;
  localparam int MEM_BYTES = 1024;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_load = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_f3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready;
  logic        mem_Rmem, mem_Wmem;
  logic [2:0]  mem_f3;
  logic [31:0] mem_addr, mem_data;
  logic [31:0] mem_rdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;
  logic        resp_misaligned, resp_fault;
  logic [31:0] cnt_loads, cnt_stores, cnt_faults;

  int passes = 0;
  int checks = 0;

  logic [7:0]  dmem    [MEM_BYTES];
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] m_loads = 0, m_stores = 0, m_faults = 0;

  lsu_ctrl #(.MEM_BYTES(MEM_BYTES), .ADDR_W(32)) dut (
    .Clock(Clock), .nReset(nReset),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_store(req_store), .req_f3(req_f3), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_Rmem(mem_Rmem), .mem_Wmem(mem_Wmem), .mem_f3(mem_f3),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
    .cnt_loads(cnt_loads), .cnt_stores(cnt_stores), .cnt_faults(cnt_faults)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f3);
    case (f3)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b001:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'd0, w[7:0]};
      3'b101:  return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dmem_word(input int a);
    return {dmem[(a+3)%MEM_BYTES], dmem[(a+2)%MEM_BYTES], dmem[(a+1)%MEM_BYTES], dmem[a%MEM_BYTES]};
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int a;
    a = int'(addr % MEM_BYTES);
    return {ref_mem[(a+3)%MEM_BYTES], ref_mem[(a+2)%MEM_BYTES], ref_mem[(a+1)%MEM_BYTES], ref_mem[a]};
  endfunction

  // Data memory: one-cycle registered read, 0 when not reading.
  always @(posedge Clock) begin : dmem_model
    int a;
    a = int'(mem_addr[9:0]);
    mem_rdata <= (mem_Rmem === 1'b1) ? extend(dmem_word(a), mem_f3) : 32'd0;
    if (mem_Wmem === 1'b1) begin
      dmem[a] = mem_data[7:0];
      if (mem_f3[1:0] != 2'b00) dmem[(a+1)%MEM_BYTES] = mem_data[15:8];
      if (mem_f3[1] == 1'b1) begin
        dmem[(a+2)%MEM_BYTES] = mem_data[23:16];
        dmem[(a+3)%MEM_BYTES] = mem_data[31:24];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_counters();
`ifdef LSU_PERF_CNT_EN
    check("cnt_loads", cnt_loads, m_loads);
    check("cnt_stores", cnt_stores, m_stores);
    check("cnt_faults", cnt_faults, m_faults);
`else
    check("cnt_tied_zero", cnt_loads | cnt_stores | cnt_faults, 32'd0);
`endif
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_req(input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int dly);
    bit          e_fault, e_mis, bad;
    int          size, lat, cyc, n_r, n_w;
    logic [31:0] e_data;

    size    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    e_fault = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2)
           || (longint'(addr) + longint'(size) > longint'(MEM_BYTES));
    e_mis   = (size == 2 && addr[0]) || (size == 4 && addr[1:0] != 2'b00);
    bad     = e_fault || e_mis;
    lat     = bad ? 1 : (ld ? 3 : 2);
    e_data  = (!bad && ld) ? extend(ref_word(addr), f3) : 32'd0;

    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_f3 = f3;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    @(negedge Clock);
    // Scramble the request bus so a design that fails to latch gets caught.
    req_valid = 1'b0; req_load = 1'(~ld); req_store = 1'(~st); req_f3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);

    cyc = 1; n_r = 0; n_w = 0;
    while (resp_valid !== 1'b1 && cyc < 8) begin
      if (mem_Rmem === 1'b1 || mem_Wmem === 1'b1) begin
        check("issue_cycle", cyc, 1);
        check("mem_addr", mem_addr, addr);
        check("mem_data", mem_data, wdata);
        check("mem_f3", {29'd0, mem_f3}, {29'd0, f3});
      end else begin
        check("mem_bus_idle", mem_addr | mem_data | {29'd0, mem_f3}, 32'd0);
      end
      if (mem_Rmem === 1'b1) n_r++;
      if (mem_Wmem === 1'b1) n_w++;
      check("req_ready_busy", req_ready, 0);
      @(negedge Clock);
      cyc++;
    end
    check("resp_latency", cyc, lat);
    check("n_rmem", n_r, (!bad && ld) ? 1 : 0);
    check("n_wmem", n_w, (!bad && st) ? 1 : 0);
    check("strobes_in_resp", {30'd0, mem_Rmem, mem_Wmem}, 32'd0);
    check("resp_data", resp_data, e_data);
    check("resp_rd", {27'd0, resp_rd}, {27'd0, rd});
    check("resp_fault", resp_fault, e_fault);
    check("resp_misaligned", resp_misaligned, e_mis);

    for (int i = 0; i < dly; i++) begin
      @(negedge Clock);
      check("hold_req_ready", req_ready, 0);
      check("hold_valid", resp_valid, 1);
      check("hold_data", resp_data, e_data);
      check("hold_tag_flags", {25'd0, resp_rd, resp_fault, resp_misaligned}, {25'd0, rd, e_fault, e_mis});
    end
    resp_ready = 1'b1;
    @(negedge Clock);
    resp_ready = 1'b0;

    if (!bad && st) begin
      for (int k = 0; k < size; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
    end
    if (bad)     m_faults = m_faults + 1;
    else if (ld) m_loads  = m_loads + 1;
    else         m_stores = m_stores + 1;

    check("resp_valid_after", resp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check_counters();
  endtask

  task automatic reset_mid_wait();
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_load = 1'b1; req_store = 1'b0; req_f3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h0; req_rd = 5'd9;
    @(negedge Clock);
    req_valid = 1'b0;
    check("rst_issue_rmem", mem_Rmem, 1);
    @(negedge Clock);
    check("rst_in_wait", {30'd0, req_ready, resp_valid}, 32'd0);
    nReset = 1'b0;
    @(negedge Clock);
    nReset = 1'b1;
    m_loads = 0; m_stores = 0; m_faults = 0;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_strobes", {30'd0, mem_Rmem, mem_Wmem}, 32'd0);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_data", resp_data, 0);
    check_counters();
    repeat (3) @(negedge Clock);
    check("rst_no_late_resp", resp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ld, st;
    int          r;
    logic [2:0]  f3;
    logic [31:0] addr;

    for (int i = 0; i < MEM_BYTES; i++) begin
      ref_mem[i] = 8'($urandom);
    end
    dmem = ref_mem;

    nReset = 1'b0;
    repeat (3) @(negedge Clock);
    check("reset_req_ready", req_ready, 1);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_strobes", {30'd0, mem_Rmem, mem_Wmem}, 32'd0);
    check("reset_mem_bus", mem_addr | mem_data | {29'd0, mem_f3}, 32'd0);
    check("reset_resp", resp_data | {27'd0, resp_rd} | {30'd0, resp_fault, resp_misaligned}, 32'd0);
    check_counters();
    nReset = 1'b1;
    @(negedge Clock);

    do_req(0, 1, 3'b010, 32'h10,  32'hDEADBEEF, 5'd3,  0);
    do_req(1, 0, 3'b010, 32'h10,  32'h0,        5'd7,  0);
    do_req(1, 0, 3'b001, 32'h21,  32'h0,        5'd1,  0);
    do_req(1, 0, 3'b010, 32'h3FE, 32'h0,        5'd2,  1);
    do_req(1, 0, 3'b011, 32'h40,  32'h0,        5'd4,  0);
    do_req(1, 1, 3'b010, 32'h40,  32'h1234,     5'd5,  0);
    do_req(0, 0, 3'b000, 32'h40,  32'h0,        5'd6,  0);
    do_req(1, 0, 3'b010, 32'h44,  32'h0,        5'd8,  5);
    do_req(0, 1, 3'b010, 32'h3FC, 32'hCAFEF00D, 5'd10, 0);
    do_req(1, 0, 3'b000, 32'h3FF, 32'h0,        5'd11, 0);
    do_req(1, 0, 3'b100, 32'h3FF, 32'h0,        5'd12, 0);
    do_req(1, 0, 3'b101, 32'h3FC, 32'h0,        5'd13, 2);
    do_req(1, 0, 3'b000, 32'hFFFFFFFF, 32'h0,   5'd14, 0);
    do_req(1, 0, 3'b001, 32'h3FF, 32'h0,        5'd15, 0);
    do_req(0, 1, 3'b100, 32'h20,  32'h55,       5'd16, 0);

    reset_mid_wait();
    do_req(1, 0, 3'b010, 32'h10,  32'h0,        5'd17, 0);

    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      begin ld = 1; st = 1; end
      else if (r == 1) begin ld = 0; st = 0; end
      else             begin ld = r[0]; st = !r[0]; end
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else if (ld)                   f3 = ($urandom_range(0, 4) == 4) ? 3'b101 : 3'($urandom_range(0, 2)) | (($urandom_range(0, 1) == 1 && f3 != 3'b010) ? 3'b100 : 3'b000);
      else                           f3 = 3'($urandom_range(0, 2));
      if ($urandom_range(0, 15) == 0) addr = $urandom;
      else begin
        addr = 32'($urandom_range(0, MEM_BYTES - 1));
        if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
      end
      do_req(ld, st, f3, addr, $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
